// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage - load/store over a req/ack port with lane steering, extension and misalign/bus-error traps
module mem_access #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ack_i,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        excp_misalign_o,
  output logic        excp_buserr_o,
  output logic        stallreq_o
);
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;
  logic [7:0] op_q;
  logic [1:0] off_q;
  logic wreg_q;
  logic [CW-1:0] cnt;
  logic is_load, is_store, is_mem, misal, go, issue, done;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] ld, st_n, wdata_n;
  logic [3:0] be_n;
  logic [4:0] wd_n;
  logic v_n, wreg_n, mis_n, berr_n;
  assign is_load  = aluop_i inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
  assign is_store = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  assign is_mem   = is_load | is_store;
  assign misal = ((aluop_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) & mem_addr_i[0]) |
                 ((aluop_i inside {EXE_LW_OP, EXE_SW_OP}) & (|mem_addr_i[1:0]));
  assign go    = state == IDLE && valid_i && !flush_i;
  assign issue = go & is_mem & !misal;
  assign done  = state == REQ && (ram_ack_i || cnt == CW'(TIMEOUT - 1));
  // Stall drops in the completing cycle so the held EX/MEM instruction is not reissued
  assign stallreq_o = issue | (state == REQ & !done);
  assign lb = ram_rdata_i[{off_q, 3'b000} +: 8];
  assign lh = ram_rdata_i[{off_q[1], 4'b0000} +: 16];
  assign ld = op_q == EXE_LB_OP  ? {{24{lb[7]}}, lb} :
              op_q == EXE_LBU_OP ? {24'b0, lb} :
              op_q == EXE_LH_OP  ? {{16{lh[15]}}, lh} :
              op_q == EXE_LHU_OP ? {16'b0, lh} : ram_rdata_i;
  assign be_n = aluop_i == EXE_SB_OP ? 4'b0001 << mem_addr_i[1:0] :
                aluop_i == EXE_SH_OP ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_n = aluop_i == EXE_SB_OP ? {4{reg2_i[7:0]}} :
                aluop_i == EXE_SH_OP ? {2{reg2_i[15:0]}} : reg2_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    v_n = 1'b0;
    wreg_n = 1'b0;
    mis_n = 1'b0;
    berr_n = 1'b0;
    wd_n = wd_o;
    wdata_n = wdata_o;
    if (go) begin
      wd_n = wd_i;
      v_n = !issue;
      wreg_n = !is_mem & wreg_i;
      wdata_n = is_mem ? wdata_o : wdata_i;
      mis_n = is_mem & misal;
      state_n = issue ? REQ : IDLE;
    end
    if (done) begin
      state_n = IDLE;
      v_n = 1'b1;
      wreg_n = ram_ack_i & wreg_q;
      wdata_n = ram_ack_i & !ram_we_o ? ld : wdata_o;
      berr_n = !ram_ack_i;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_req_o <= 1'b0;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_be_o <= '0;
      ram_wdata_o <= '0;
      valid_o <= 1'b0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      wdata_o <= '0;
      excp_misalign_o <= 1'b0;
      excp_buserr_o <= 1'b0;
      op_q <= '0;
      off_q <= '0;
      wreg_q <= 1'b0;
      cnt <= '0;
    end else begin
      valid_o <= v_n;
      wd_o <= wd_n;
      wreg_o <= wreg_n;
      wdata_o <= wdata_n;
      excp_misalign_o <= mis_n;
      excp_buserr_o <= berr_n;
      if (issue) begin
        ram_req_o <= 1'b1;
        ram_we_o <= is_store;
        ram_addr_o <= {mem_addr_i[31:2], 2'b00};
        ram_be_o <= be_n;
        ram_wdata_o <= st_n;
        op_q <= aluop_i;
        off_q <= mem_addr_i[1:0];
        wreg_q <= is_load & wreg_i;
        cnt <= '0;
      end else if (done) ram_req_o <= 1'b0;
      else if (state == REQ) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for the MEM stage against an arithmetic reference model
module tb_mem_access;
  localparam int TMO = 8;
  localparam logic [7:0] LB = 8'he0, LH = 8'he1, LW = 8'he3, LBU = 8'he4, LHU = 8'he5;
  localparam logic [7:0] SB = 8'he8, SH = 8'he9, SW = 8'heb, ADD = 8'h20;
  logic clk = 0, rst = 1, valid_i = 0, flush_i = 0, wreg_i = 0, ram_ack_i = 0;
  logic [7:0] aluop_i = 0;
  logic [31:0] mem_addr_i = 0, reg2_i = 0, wdata_i = 0, ram_rdata_i = 0;
  logic [4:0] wd_i = 0;
  logic ram_req_o, ram_we_o, valid_o, wreg_o, excp_misalign_o, excp_buserr_o, stallreq_o;
  logic [31:0] ram_addr_o, ram_wdata_o, wdata_o;
  logic [3:0] ram_be_o;
  logic [4:0] wd_o;
  int n_cmp = 0, n_bad = 0;

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .excp_misalign_o(excp_misalign_o), .excp_buserr_o(excp_buserr_o), .stallreq_o(stallreq_o));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    if (op == LB) return sh[7] ? sh[7:0] - 32'd256 : {24'b0, sh[7:0]};
    if (op == LBU) return {24'b0, sh[7:0]};
    if (op == LH) return sh[15] ? sh[15:0] - 32'd65536 : {16'b0, sh[15:0]};
    if (op == LHU) return {16'b0, sh[15:0]};
    return rd;
  endfunction

  task automatic test_reset;
    step;
    step;
    n_cmp++;
    if ({ram_req_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o, valid_o, wd_o, wreg_o, wdata_o,
         excp_misalign_o, excp_buserr_o, stallreq_o} !== '0)
      begin n_bad++; $display("FAIL reset_outputs: got req=%b be=%h addr=%h valid=%b wdata=%h, want all 0", ram_req_o, ram_be_o, ram_addr_o, valid_o, wdata_o); end
    rst = 0;
    step;
  endtask

  task automatic test_alu_passthrough;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      logic [4:0] w;
      logic [7:0] op;
      d = i == 0 ? 32'h1234 : $urandom;
      w = i == 0 ? 5'd5 : 5'($urandom);
      op = i == 0 ? ADD : 8'($urandom_range(0, 8'hdf));
      valid_i = 1; flush_i = 0; aluop_i = op; wdata_i = d; wd_i = w; wreg_i = 1;
      mem_addr_i = $urandom; reg2_i = $urandom;
      #1;
      n_cmp++;
      if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stallreq_o); end
      step;
      n_cmp++;
      if ({valid_o, wdata_o, wd_o, wreg_o, ram_req_o} !== {1'b1, d, w, 1'b1, 1'b0})
        begin n_bad++; $display("FAIL alu_pass: got v=%b d=%h wd=%0d wreg=%b req=%b want v=1 d=%h wd=%0d wreg=1 req=0", valid_o, wdata_o, wd_o, wreg_o, ram_req_o, d, w); end
    end
    valid_i = 0;
    step;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL alu_pulse: got %b want 0", valid_o); end
  endtask

  task automatic test_load;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] op;
      logic [31:0] a, rd, exp;
      logic [4:0] w;
      int d, stalls, pick;
      pick = $urandom_range(0, 4);
      op = pick == 0 ? LB : pick == 1 ? LBU : pick == 2 ? LH : pick == 3 ? LHU : LW;
      a = $urandom;
      a = op == LW ? a & ~32'h3 : (op == LH || op == LHU) ? a & ~32'h1 : a;
      rd = $urandom;
      d = $urandom_range(0, 5);
      if (i == 0) begin op = LB; a = 32'h103; rd = 32'h80FF_0011; d = 3; end
      if (i == 1) d = TMO - 1;
      w = 5'($urandom_range(1, 31));
      exp = model_load(op, a, rd);
      valid_i = 1; flush_i = 0; aluop_i = op; mem_addr_i = a; wd_i = w; wreg_i = 1;
      wdata_i = $urandom; reg2_i = $urandom;
      stalls = 0;
      #1;
      if (stallreq_o) stalls++;
      step;
      n_cmp++;
      if ({ram_req_o, ram_we_o, ram_be_o, ram_addr_o} !== {1'b1, 1'b0, 4'hf, a[31:2], 2'b00})
        begin n_bad++; $display("FAIL load_req: got req=%b we=%b be=%h addr=%h want 1 0 f %h", ram_req_o, ram_we_o, ram_be_o, ram_addr_o, {a[31:2], 2'b00}); end
      for (int k = 0; k <= d; k++) begin
        ram_ack_i = k == d;
        ram_rdata_i = k == d ? rd : $urandom;
        #1;
        if (stallreq_o) stalls++;
        step;
      end
      ram_ack_i = 0; valid_i = 0;
      n_cmp++;
      if ({valid_o, wdata_o, wd_o, wreg_o, ram_req_o, excp_buserr_o, excp_misalign_o} !== {1'b1, exp, w, 1'b1, 3'b000})
        begin n_bad++; $display("FAIL load_result op=%h a=%h: got v=%b d=%h wd=%0d wreg=%b req=%b berr=%b want v=1 d=%h wd=%0d wreg=1 req=0 berr=0", op, a, valid_o, wdata_o, wd_o, wreg_o, ram_req_o, excp_buserr_o, exp, w); end
      n_cmp++;
      if (stalls !== d + 1) begin n_bad++; $display("FAIL load_stall_cycles: got %0d want %0d", stalls, d + 1); end
      step;
      n_cmp++;
      if ({valid_o, ram_req_o} !== 2'b00) begin n_bad++; $display("FAIL load_once: got v=%b req=%b want 0 0", valid_o, ram_req_o); end
    end
  endtask

  task automatic test_store;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] op;
      logic [31:0] a, rs, ew;
      logic [3:0] eb;
      int d, pick;
      pick = $urandom_range(0, 2);
      op = pick == 0 ? SB : pick == 1 ? SH : SW;
      a = $urandom;
      rs = $urandom;
      d = $urandom_range(0, 4);
      if (i == 0) begin op = SH; a = 32'h202; rs = 32'hDEAD_BEEF; d = 2; end
      a = op == SW ? a & ~32'h3 : op == SH ? a & ~32'h1 : a;
      eb = op == SB ? 4'(1 << a[1:0]) : op == SH ? 4'(3 << a[1:0]) : 4'hf;
      ew = op == SB ? 32'h0101_0101 * rs[7:0] : op == SH ? 32'h0001_0001 * rs[15:0] : rs;
      valid_i = 1; flush_i = 0; aluop_i = op; mem_addr_i = a; reg2_i = rs; wd_i = 5'd9; wreg_i = 1;
      wdata_i = $urandom;
      step;
      n_cmp++;
      if ({ram_req_o, ram_we_o, ram_be_o, ram_wdata_o, ram_addr_o} !== {1'b1, 1'b1, eb, ew, a[31:2], 2'b00})
        begin n_bad++; $display("FAIL store_req op=%h a=%h: got req=%b we=%b be=%b wd=%h addr=%h want 1 1 %b %h %h", op, a, ram_req_o, ram_we_o, ram_be_o, ram_wdata_o, ram_addr_o, eb, ew, {a[31:2], 2'b00}); end
      mem_addr_i = $urandom; reg2_i = $urandom;
      for (int k = 0; k <= d; k++) begin
        ram_ack_i = k == d;
        if (k == d) begin
          n_cmp++;
          if ({ram_req_o, ram_be_o, ram_wdata_o} !== {1'b1, eb, ew})
            begin n_bad++; $display("FAIL store_stable: got req=%b be=%b wd=%h want 1 %b %h", ram_req_o, ram_be_o, ram_wdata_o, eb, ew); end
        end
        step;
      end
      ram_ack_i = 0; valid_i = 0;
      n_cmp++;
      if ({valid_o, wreg_o, ram_req_o, excp_buserr_o} !== 4'b1000)
        begin n_bad++; $display("FAIL store_done: got v=%b wreg=%b req=%b berr=%b want 1 0 0 0", valid_o, wreg_o, ram_req_o, excp_buserr_o); end
      step;
    end
  endtask

  task automatic test_misalign;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] op;
      logic [31:0] a;
      int pick;
      pick = $urandom_range(0, 4);
      op = pick == 0 ? LH : pick == 1 ? LHU : pick == 2 ? SH : pick == 3 ? LW : SW;
      a = $urandom;
      if (op == LW || op == SW) a[1:0] = 2'($urandom_range(1, 3));
      else a[0] = 1'b1;
      if (i == 0) begin op = LW; a = 32'h101; end
      valid_i = 1; flush_i = 0; aluop_i = op; mem_addr_i = a; wd_i = 5'd3; wreg_i = 1; reg2_i = $urandom;
      #1;
      n_cmp++;
      if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL misalign_stall: got %b want 0", stallreq_o); end
      step;
      n_cmp++;
      if ({valid_o, excp_misalign_o, wreg_o, ram_req_o, excp_buserr_o} !== 5'b11000)
        begin n_bad++; $display("FAIL misalign op=%h a=%h: got v=%b mis=%b wreg=%b req=%b want 1 1 0 0", op, a, valid_o, excp_misalign_o, wreg_o, ram_req_o); end
      valid_i = 0;
      step;
      n_cmp++;
      if ({valid_o, excp_misalign_o, ram_req_o} !== 3'b000)
        begin n_bad++; $display("FAIL misalign_after: got v=%b mis=%b req=%b want 0 0 0", valid_o, excp_misalign_o, ram_req_o); end
    end
  endtask

  task automatic test_flush_idle;
    valid_i = 1; flush_i = 1; aluop_i = LW; mem_addr_i = 32'h400; wreg_i = 1; ram_ack_i = 1;
    #1;
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stallreq_o); end
    step;
    n_cmp++;
    if ({valid_o, ram_req_o} !== 2'b00) begin n_bad++; $display("FAIL flush_idle: got v=%b req=%b want 0 0", valid_o, ram_req_o); end
    valid_i = 0; flush_i = 0;
    step;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stray_ack: got v=%b want 0", valid_o); end
    ram_ack_i = 0;
  endtask

  task automatic test_timeout;
    int reqcyc = 0;
    valid_i = 1; flush_i = 0; aluop_i = LW; mem_addr_i = 32'h800; wd_i = 5'd7; wreg_i = 1;
    step;
    for (int k = 0; k < TMO; k++) begin
      if (ram_req_o) reqcyc++;
      flush_i = 1'($urandom);
      step;
    end
    flush_i = 0; valid_i = 0;
    n_cmp++;
    if (reqcyc !== TMO) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want %0d", reqcyc, TMO); end
    n_cmp++;
    if ({valid_o, excp_buserr_o, wreg_o, ram_req_o, excp_misalign_o} !== 5'b11000)
      begin n_bad++; $display("FAIL timeout_err: got v=%b berr=%b wreg=%b req=%b want 1 1 0 0", valid_o, excp_buserr_o, wreg_o, ram_req_o); end
    step;
    n_cmp++;
    if ({valid_o, excp_buserr_o, ram_req_o} !== 3'b000)
      begin n_bad++; $display("FAIL timeout_after: got v=%b berr=%b req=%b want 0 0 0", valid_o, excp_buserr_o, ram_req_o); end
  endtask

  task automatic test_reset_mid_req;
    valid_i = 1; flush_i = 0; aluop_i = LB; mem_addr_i = 32'h10; wd_i = 5'd4; wreg_i = 1;
    step;
    n_cmp++;
    if (ram_req_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %b want 1", ram_req_o); end
    valid_i = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({ram_req_o, valid_o} !== 2'b00) begin n_bad++; $display("FAIL rst_async: got req=%b v=%b want 0 0", ram_req_o, valid_o); end
    ram_ack_i = 1;
    step;
    rst = 0; ram_ack_i = 0;
    step;
    n_cmp++;
    if ({ram_req_o, valid_o} !== 2'b00) begin n_bad++; $display("FAIL rst_abandon: got req=%b v=%b want 0 0", ram_req_o, valid_o); end
    valid_i = 1; aluop_i = ADD; wdata_i = 32'hCAFE_0001; wd_i = 5'd11;
    step;
    valid_i = 0;
    n_cmp++;
    if ({valid_o, wdata_o, wd_o} !== {1'b1, 32'hCAFE_0001, 5'd11})
      begin n_bad++; $display("FAIL rst_idle_after: got v=%b d=%h wd=%0d want 1 cafe0001 11", valid_o, wdata_o, wd_o); end
  endtask

  initial begin
    test_reset;
    test_alu_passthrough;
    test_load;
    test_store;
    test_misalign;
    test_flush_idle;
    test_timeout;
    test_reset_mid_req;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
